// File: rtl/cpu_ctrl_pkg.sv
// ==== cpu_ctrl_pkg : opcodes, FSM states and decode helpers for alu_instr_sequencer (rev 1.0) ====
`default_nettype none

package cpu_ctrl_pkg;

  localparam int OPC_BITS = 5;
  localparam int ALU_OP_W = 13;

  localparam logic [OPC_BITS-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_BITS-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_BITS-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPC_BITS-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPC_BITS-1:0] OPC_ROL  = 5'b00111;
  localparam logic [OPC_BITS-1:0] OPC_ROR  = 5'b01000;
  localparam logic [OPC_BITS-1:0] OPC_SHR  = 5'b01001;
  localparam logic [OPC_BITS-1:0] OPC_SHRA = 5'b01010;
  localparam logic [OPC_BITS-1:0] OPC_SHL  = 5'b01011;
  localparam logic [OPC_BITS-1:0] OPC_MUL  = 5'b01111;
  localparam logic [OPC_BITS-1:0] OPC_DIV  = 5'b10000;
  localparam logic [OPC_BITS-1:0] OPC_NEG  = 5'b10001;
  localparam logic [OPC_BITS-1:0] OPC_NOT  = 5'b10010;

  // alu_op bit positions, ADD is the MSB
  localparam int ALU_ADD  = 12;
  localparam int ALU_SUB  = 11;
  localparam int ALU_AND  = 10;
  localparam int ALU_OR   = 9;
  localparam int ALU_ROL  = 8;
  localparam int ALU_ROR  = 7;
  localparam int ALU_SHR  = 6;
  localparam int ALU_SHRA = 5;
  localparam int ALU_SHL  = 4;
  localparam int ALU_MUL  = 3;
  localparam int ALU_DIV  = 2;
  localparam int ALU_NEG  = 1;
  localparam int ALU_NOT  = 0;

  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, DONE} state_t;

  typedef enum logic [1:0] {CLS_3REG, CLS_UNARY, CLS_MULDIV, CLS_ILLEGAL} instr_cls_t;

  function automatic instr_cls_t instr_class(input logic [OPC_BITS-1:0] opc);
    instr_cls_t cls;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ROL,
      OPC_ROR, OPC_SHR, OPC_SHRA, OPC_SHL: cls = CLS_3REG;
      OPC_NEG, OPC_NOT:                    cls = CLS_UNARY;
      OPC_MUL, OPC_DIV:                    cls = CLS_MULDIV;
      default:                             cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic [ALU_OP_W-1:0] alu_onehot(input logic [OPC_BITS-1:0] opc);
    logic [ALU_OP_W-1:0] oh;
    oh = '0;
    case (opc)
      OPC_ADD:  oh[ALU_ADD]  = 1'b1;
      OPC_SUB:  oh[ALU_SUB]  = 1'b1;
      OPC_AND:  oh[ALU_AND]  = 1'b1;
      OPC_OR:   oh[ALU_OR]   = 1'b1;
      OPC_ROL:  oh[ALU_ROL]  = 1'b1;
      OPC_ROR:  oh[ALU_ROR]  = 1'b1;
      OPC_SHR:  oh[ALU_SHR]  = 1'b1;
      OPC_SHRA: oh[ALU_SHRA] = 1'b1;
      OPC_SHL:  oh[ALU_SHL]  = 1'b1;
      OPC_MUL:  oh[ALU_MUL]  = 1'b1;
      OPC_DIV:  oh[ALU_DIV]  = 1'b1;
      OPC_NEG:  oh[ALU_NEG]  = 1'b1;
      OPC_NOT:  oh[ALU_NOT]  = 1'b1;
      default:  oh = '0;
    endcase
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_onehot_decoder.sv
// ==== reg_onehot_decoder : register index plus enable to one-hot select bus (rev 1.0) ====
`default_nettype none

module reg_onehot_decoder #(
  parameter int REG_COUNT = 16,
  parameter int REG_IDX_W = 4
) (
  input  logic [REG_IDX_W-1:0] i_idx,
  input  logic                 i_en,
  output logic [REG_COUNT-1:0] o_onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_bit
      assign o_onehot[gi] = i_en && (i_idx == REG_IDX_W'(gi));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/alu_instr_sequencer.sv
// ==== alu_instr_sequencer : fetch/decode/execute control FSM for register ALU ops (rev 1.0) ====
`default_nettype none

module alu_instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int REG_COUNT = 16,
  parameter int REG_IDX_W = 4,
  parameter int OPC_W     = 5
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 mem_ready,
  input  logic [WORD_W-1:0]    ir,
  output logic [REG_COUNT-1:0] Rin,
  output logic [REG_COUNT-1:0] Rout,
  output logic                 PCout,
  output logic                 PCin,
  output logic                 IncPC,
  output logic                 MARin,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 MDMuxread,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 Zlowin,
  output logic                 Zhighin,
  output logic                 Zlowout,
  output logic                 Zhighout,
  output logic                 HIin,
  output logic                 LOin,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal
);

  localparam int RA_MSB = WORD_W - OPC_W - 1;
  localparam int RB_MSB = RA_MSB - REG_IDX_W;
  localparam int RC_MSB = RB_MSB - REG_IDX_W;
  localparam int RC_LSB = RC_MSB - REG_IDX_W + 1;

  state_t                r_state;
  logic                  r_t1_first;
  instr_cls_t            r_cls;
  logic [ALU_OP_W-1:0]   r_alu;
  logic [REG_IDX_W-1:0]  r_ra, r_rb, r_rc;

  logic [OPC_W-1:0]      w_opc;
  logic [REG_IDX_W-1:0]  w_ra, w_rb, w_rc;
  logic                  w_ra_ok, w_rb_ok, w_rc_ok;
  instr_cls_t            w_cls_raw, w_cls;

  assign w_opc = ir[WORD_W-1 -: OPC_W];
  assign w_ra  = ir[RA_MSB -: REG_IDX_W];
  assign w_rb  = ir[RB_MSB -: REG_IDX_W];
  assign w_rc  = ir[RC_MSB -: REG_IDX_W];

  generate
    if (RC_LSB > 0) begin : g_unused
      logic w_unused_ir;
      assign w_unused_ir = ^ir[RC_LSB-1:0];
    end
  endgenerate

  assign w_ra_ok   = 32'(w_ra) < 32'(REG_COUNT);
  assign w_rb_ok   = 32'(w_rb) < 32'(REG_COUNT);
  assign w_rc_ok   = 32'(w_rc) < 32'(REG_COUNT);
  assign w_cls_raw = instr_class(OPC_BITS'(w_opc));

  // Out-of-range register fields demote a legal opcode to the illegal path
  always_comb begin
    w_cls = w_cls_raw;
    case (w_cls_raw)
      CLS_3REG:   if (!(w_ra_ok && w_rb_ok && w_rc_ok)) w_cls = CLS_ILLEGAL;
      CLS_UNARY,
      CLS_MULDIV: if (!(w_ra_ok && w_rb_ok))            w_cls = CLS_ILLEGAL;
      default:    w_cls = w_cls_raw;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state    <= IDLE;
      r_t1_first <= 1'b0;
      r_cls      <= CLS_ILLEGAL;
      r_alu      <= '0;
      r_ra       <= '0;
      r_rb       <= '0;
      r_rc       <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) r_state <= T0;
        T0: begin
          r_state    <= T1;
          r_t1_first <= 1'b1;
        end
        T1: begin
          r_t1_first <= 1'b0;
          if (mem_ready) r_state <= T2;
        end
        T2: begin
          r_cls   <= w_cls;
          r_alu   <= alu_onehot(OPC_BITS'(w_opc));
          r_ra    <= w_ra;
          r_rb    <= w_rb;
          r_rc    <= w_rc;
          r_state <= T3;
        end
        T3:      r_state <= (r_cls == CLS_ILLEGAL) ? DONE : T4;
        T4:      r_state <= (r_cls == CLS_UNARY)   ? DONE : T5;
        T5:      r_state <= (r_cls == CLS_3REG)    ? DONE : T6;
        T6:      r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  logic                 w_rout_en, w_rin_en;
  logic [REG_IDX_W-1:0] w_rout_idx;

  always_comb begin
    w_rout_en  = 1'b0;
    w_rout_idx = r_rb;
    w_rin_en   = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; MDMuxread = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zlowin = 1'b0; Zhighin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    HIin = 1'b0; LOin = 1'b0;
    alu_op = '0;
    case (r_state)
      T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
      end
      T1: begin
        PCin      = r_t1_first;
        Zlowout   = r_t1_first;
        MDMuxread = 1'b1;
        MDRin     = 1'b1;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      T3: begin
        case (r_cls)
          CLS_3REG:   begin w_rout_en = 1'b1; Yin = 1'b1; end
          CLS_UNARY:  begin
            w_rout_en = 1'b1; alu_op = r_alu; Zlowin = 1'b1; Zhighin = 1'b1;
          end
          CLS_MULDIV: begin w_rout_en = 1'b1; w_rout_idx = r_ra; Yin = 1'b1; end
          default:    w_rout_en = 1'b0;
        endcase
      end
      T4: begin
        case (r_cls)
          CLS_3REG: begin
            w_rout_en = 1'b1; w_rout_idx = r_rc;
            alu_op = r_alu; Zlowin = 1'b1; Zhighin = 1'b1;
          end
          CLS_UNARY:  begin Zlowout = 1'b1; w_rin_en = 1'b1; end
          CLS_MULDIV: begin
            w_rout_en = 1'b1; alu_op = r_alu; Zlowin = 1'b1; Zhighin = 1'b1;
          end
          default:    w_rout_en = 1'b0;
        endcase
      end
      T5: begin
        Zlowout  = (r_cls == CLS_3REG) || (r_cls == CLS_MULDIV);
        w_rin_en = (r_cls == CLS_3REG);
        LOin     = (r_cls == CLS_MULDIV);
      end
      T6: begin
        Zhighout = 1'b1; HIin = 1'b1;
      end
      default: w_rout_en = 1'b0;
    endcase
  end

  reg_onehot_decoder #(.REG_COUNT(REG_COUNT), .REG_IDX_W(REG_IDX_W)) u_rout_dec (
    .i_idx    (w_rout_idx),
    .i_en     (w_rout_en),
    .o_onehot (Rout)
  );

  reg_onehot_decoder #(.REG_COUNT(REG_COUNT), .REG_IDX_W(REG_IDX_W)) u_rin_dec (
    .i_idx    (r_ra),
    .i_en     (w_rin_en),
    .o_onehot (Rin)
  );

  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign illegal = (r_state == DONE) && (r_cls == CLS_ILLEGAL);

endmodule

`default_nettype wire

// File: tb/tb_alu_instr_sequencer.sv
// ==== tb_alu_instr_sequencer : directed vector bench for alu_instr_sequencer (rev 1.0) ====
`default_nettype none

module tb_alu_instr_sequencer;

  logic        clock, clear, start, mem_ready;
  logic [31:0] ir;
  logic [15:0] Rin, Rout;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin, Yin;
  logic        Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
  logic [12:0] alu_op;
  logic        busy, done, illegal;
  logic [62:0] all_o;

  int errors = 0;
  int checks = 0;

  alu_instr_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
    .Rin(Rin), .Rout(Rout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .MDMuxread(MDMuxread), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin), .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal)
  );

  assign all_o = {Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, IRin, Yin,
                  Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, alu_op, busy, done, illegal};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  opc;
    logic [3:0]  ra, rb, rc;
    logic [3:0]  waits;
    logic [4:0]  lat;
    logic        ill;
    logic [15:0] t3_rout;
    logic [12:0] t3_alu;
    logic [15:0] t4_rout;
    logic [12:0] t4_alu;
    logic [15:0] rin;
    logic [1:0]  yin_n, lo_n, hi_n, zlo_n;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] c);
    return {opc, a, b, c, 15'b0};
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int          n, w, lat, yin_n, lo_n, hi_n, zlo_n, pcin_n, mdrin_n;
    logic        got, ill, bad;
    logic [15:0] t3_rout, t4_rout, rin_or;
    logic [12:0] t3_alu, t4_alu;
    w = int'(v.waits);
    n = 0; lat = 0; got = 1'b0; ill = 1'b0; bad = 1'b0;
    yin_n = 0; lo_n = 0; hi_n = 0; zlo_n = 0; pcin_n = 0; mdrin_n = 0;
    t3_rout = '0; t4_rout = '0; rin_or = '0; t3_alu = '0; t4_alu = '0;
    ir = mk(v.opc, v.ra, v.rb, v.rc);
    mem_ready = 1'b0;
    start = 1'b1;
    while (!got && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (n == 4 + w) begin t3_rout = Rout; t3_alu = alu_op; end
      if (n == 5 + w) begin t4_rout = Rout; t4_alu = alu_op; end
      rin_or |= Rin;
      yin_n += int'(Yin); lo_n += int'(LOin); hi_n += int'(HIin);
      zlo_n += int'(Zlowout); pcin_n += int'(PCin); mdrin_n += int'(MDRin);
      if ($countones(Rout) > 1 || $countones(alu_op) > 1 ||
          (Rout != 0 && (PCout || MDRout || Zlowout)) || HIin != Zhighout) bad = 1'b1;
      if (done) begin got = 1'b1; lat = n; ill = illegal; end
      start     = (n == 2);
      mem_ready = (n >= 2 + w);
      if (n == 4 + w) ir = 32'hFFFF_FFFF;
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", tag);
    end
    chk({tag, "_lat"},     64'(lat),     64'(v.lat));
    chk({tag, "_illegal"}, 64'(ill),     64'(v.ill));
    chk({tag, "_t3_rout"}, 64'(t3_rout), 64'(v.t3_rout));
    chk({tag, "_t3_alu"},  64'(t3_alu),  64'(v.t3_alu));
    chk({tag, "_t4_rout"}, 64'(t4_rout), 64'(v.t4_rout));
    chk({tag, "_t4_alu"},  64'(t4_alu),  64'(v.t4_alu));
    chk({tag, "_rin"},     64'(rin_or),  64'(v.rin));
    chk({tag, "_yin_n"},   64'(yin_n),   64'(v.yin_n));
    chk({tag, "_lo_n"},    64'(lo_n),    64'(v.lo_n));
    chk({tag, "_hi_n"},    64'(hi_n),    64'(v.hi_n));
    chk({tag, "_zlo_n"},   64'(zlo_n),   64'(v.zlo_n));
    chk({tag, "_pcin_n"},  64'(pcin_n),  64'd1);
    chk({tag, "_mdrin_n"}, 64'(mdrin_n), 64'(w + 1));
    chk({tag, "_invariants"}, 64'(bad), 64'd0);
    start = 1'b1;
    @(posedge clock); #1;
    chk({tag, "_start_in_done_dropped"}, 64'({busy, done}), 64'd0);
    start = 1'b0;
    mem_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    //           opc       ra    rb    rc    W     lat    ill   t3_rout   t3_alu    t4_rout   t4_alu    rin       yin lo hi zlo
    vecs[0]  = '{5'b01000, 4'd1, 4'd2, 4'd3, 4'd0, 5'd7,  1'b0, 16'h0004, 13'h0000, 16'h0008, 13'h0080, 16'h0002, 2'd1, 2'd0, 2'd0, 2'd2};
    vecs[1]  = '{5'b01111, 4'd3, 4'd4, 4'd0, 4'd0, 5'd8,  1'b0, 16'h0008, 13'h0000, 16'h0010, 13'h0008, 16'h0000, 2'd1, 2'd1, 2'd1, 2'd2};
    vecs[2]  = '{5'b10001, 4'd5, 4'd6, 4'd0, 4'd0, 5'd6,  1'b0, 16'h0040, 13'h0002, 16'h0000, 13'h0000, 16'h0020, 2'd0, 2'd0, 2'd0, 2'd2};
    vecs[3]  = '{5'b11111, 4'd0, 4'd0, 4'd0, 4'd0, 5'd5,  1'b1, 16'h0000, 13'h0000, 16'h0000, 13'h0000, 16'h0000, 2'd0, 2'd0, 2'd0, 2'd1};
    vecs[4]  = '{5'b01000, 4'd1, 4'd2, 4'd3, 4'd3, 5'd10, 1'b0, 16'h0004, 13'h0000, 16'h0008, 13'h0080, 16'h0002, 2'd1, 2'd0, 2'd0, 2'd2};
    vecs[5]  = '{5'b00011, 4'd7, 4'd8, 4'd9, 4'd0, 5'd7,  1'b0, 16'h0100, 13'h0000, 16'h0200, 13'h1000, 16'h0080, 2'd1, 2'd0, 2'd0, 2'd2};
    vecs[6]  = '{5'b10010, 4'd15,4'd0, 4'd0, 4'd0, 5'd6,  1'b0, 16'h0001, 13'h0001, 16'h0000, 13'h0000, 16'h8000, 2'd0, 2'd0, 2'd0, 2'd2};
    vecs[7]  = '{5'b10000, 4'd14,4'd15,4'd0, 4'd1, 5'd9,  1'b0, 16'h4000, 13'h0000, 16'h8000, 13'h0004, 16'h0000, 2'd1, 2'd1, 2'd1, 2'd2};
    vecs[8]  = '{5'b01010, 4'd0, 4'd15,4'd14,4'd2, 5'd9,  1'b0, 16'h8000, 13'h0000, 16'h4000, 13'h0020, 16'h0001, 2'd1, 2'd0, 2'd0, 2'd2};
    vecs[9]  = '{5'b00000, 4'd3, 4'd3, 4'd3, 4'd0, 5'd5,  1'b1, 16'h0000, 13'h0000, 16'h0000, 13'h0000, 16'h0000, 2'd0, 2'd0, 2'd0, 2'd1};
    vecs[10] = '{5'b00100, 4'd2, 4'd2, 4'd2, 4'd0, 5'd7,  1'b0, 16'h0004, 13'h0000, 16'h0004, 13'h0800, 16'h0004, 2'd1, 2'd0, 2'd0, 2'd2};
    vecs[11] = '{5'b01100, 4'd1, 4'd1, 4'd1, 4'd1, 5'd6,  1'b1, 16'h0000, 13'h0000, 16'h0000, 13'h0000, 16'h0000, 2'd0, 2'd0, 2'd0, 2'd1};

    clear = 1'b1; start = 1'b1; mem_ready = 1'b0; ir = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_all_zero", 64'(all_o), 64'd0);
    chk("reset_vec0_ir", 64'(mk(vecs[0].opc, vecs[0].ra, vecs[0].rb, vecs[0].rc)), 64'h4091_8000);
    clear = 1'b0; start = 1'b0;
    @(posedge clock); #1;
    chk("idle_after_reset", 64'(busy), 64'd0);

    for (int i = 0; i < 12; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Clear while a ROR sits in T4, with start also high
    ir = 32'h4091_8000; mem_ready = 1'b1; start = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clock); #1;
      if (n == 1) start = 1'b0;
    end
    chk("clr_pre_t4_rout", 64'(Rout), 64'h0008);
    chk("clr_pre_t4_alu", 64'(alu_op), 64'h0080);
    clear = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    chk("clr_all_zero", 64'(all_o), 64'd0);
    clear = 1'b0; start = 1'b0;
    @(posedge clock); #1;
    chk("clr_beats_start", 64'(busy), 64'd0);
    run_vec("rerun", vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
